// File: rtl/btn_event_decoder.sv
// Centre push-button front end: two-flop synchroniser, debouncer, and a
// click / double-click / long-press classifier with one-cycle event pulses.
module btn_event_decoder #(
    parameter int unsigned DEB_CYCLES  = 1_000_000,
    parameter int unsigned LONG_CYCLES = 100_000_000,
    parameter int unsigned DBL_CYCLES  = 30_000_000,
    parameter int unsigned CW          = 27
) (
    input  logic clk,
    input  logic sw,
    input  logic btnC,
    output logic pressed,
    output logic click,
    output logic dbl_click,
    output logic long_press
);

    localparam logic [CW-1:0] DEB_TC  = CW'(DEB_CYCLES - 1);
    localparam logic [CW-1:0] LONG_TC = CW'(LONG_CYCLES - 1);
    localparam logic [CW-1:0] DBL_TC  = CW'(DBL_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HELD1,
        ST_GAP,
        ST_HELD2,
        ST_LONG
    } state_e;

    logic          btn_s1_q;
    logic          btn_s2_q;
    logic          pressed_q;
    logic          pressed_d;
    logic [CW-1:0] deb_cnt_q;
    logic [CW-1:0] deb_cnt_d;
    logic          rise_c;
    logic          fall_c;

    state_e        state_q;
    state_e        state_d;
    logic [CW-1:0] tmr_q;
    logic [CW-1:0] tmr_d;
    logic          click_q;
    logic          click_d;
    logic          dbl_click_q;
    logic          dbl_click_d;
    logic          long_press_q;
    logic          long_press_d;

    // Debounce: pressed follows btn_s2 only after it has differed for DEB_CYCLES edges.
    always_comb begin
        pressed_d = pressed_q;
        deb_cnt_d = deb_cnt_q;
        rise_c    = 1'b0;
        fall_c    = 1'b0;
        if (btn_s2_q == pressed_q) begin
            deb_cnt_d = '0;
        end else if (deb_cnt_q == DEB_TC) begin
            pressed_d = btn_s2_q;
            deb_cnt_d = '0;
            rise_c    = btn_s2_q;
            fall_c    = !btn_s2_q;
        end else begin
            deb_cnt_d = deb_cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (sw) begin
            btn_s1_q  <= 1'b0;
            btn_s2_q  <= 1'b0;
            pressed_q <= 1'b0;
            deb_cnt_q <= '0;
        end else begin
            btn_s1_q  <= btnC;
            btn_s2_q  <= btn_s1_q;
            pressed_q <= pressed_d;
            deb_cnt_q <= deb_cnt_d;
        end
    end

    // Gesture classifier; edge strobes win over a timeout on the same cycle.
    always_comb begin
        state_d      = state_q;
        click_d      = 1'b0;
        dbl_click_d  = 1'b0;
        long_press_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rise_c) state_d = ST_HELD1;
            end
            ST_HELD1: begin
                if (fall_c) begin
                    state_d = ST_GAP;
                end else if (tmr_q == LONG_TC) begin
                    long_press_d = 1'b1;
                    state_d      = ST_LONG;
                end
            end
            ST_GAP: begin
                if (rise_c) begin
                    state_d = ST_HELD2;
                end else if (tmr_q == DBL_TC) begin
                    click_d = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_HELD2: begin
                if (fall_c) begin
                    dbl_click_d = 1'b1;
                    state_d     = ST_IDLE;
                end else if (tmr_q == LONG_TC) begin
                    long_press_d = 1'b1;
                    state_d      = ST_LONG;
                end
            end
            ST_LONG: begin
                if (fall_c) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_d != state_q) begin
            tmr_d = '0;
        end else if (state_q == ST_HELD1 || state_q == ST_GAP || state_q == ST_HELD2) begin
            tmr_d = tmr_q + CW'(1);
        end else begin
            tmr_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (sw) begin
            state_q      <= ST_IDLE;
            tmr_q        <= '0;
            click_q      <= 1'b0;
            dbl_click_q  <= 1'b0;
            long_press_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            tmr_q        <= tmr_d;
            click_q      <= click_d;
            dbl_click_q  <= dbl_click_d;
            long_press_q <= long_press_d;
        end
    end

    assign pressed    = pressed_q;
    assign click      = click_q;
    assign dbl_click  = dbl_click_q;
    assign long_press = long_press_q;

endmodule

// File: tb/tb_btn_event_decoder.sv
// Bench for btn_event_decoder: directed gestures plus random button activity,
// checked every cycle against a timestamp-based gesture model.
module tb_btn_event_decoder;

    localparam int DEB  = 4;
    localparam int LONG = 40;
    localparam int DBL  = 16;

    logic clk  = 1'b0;
    logic sw   = 1'b1;
    logic btnC = 1'b0;
    logic pressed;
    logic click;
    logic dbl_click;
    logic long_press;

    btn_event_decoder #(
        .DEB_CYCLES (DEB),
        .LONG_CYCLES(LONG),
        .DBL_CYCLES (DBL),
        .CW         (8)
    ) dut (
        .clk       (clk),
        .sw        (sw),
        .btnC      (btnC),
        .pressed   (pressed),
        .click     (click),
        .dbl_click (dbl_click),
        .long_press(long_press)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model state: sample delay line, debounce run length, gesture timestamps.
    int cyc      = 0;
    bit dl0      = 1'b0;
    bit dl1      = 1'b0;
    int run      = 0;
    bit m_pressed = 1'b0;
    int m_presses = 0;
    bit m_long   = 1'b0;
    int t_mark   = 0;
    bit e_click  = 1'b0;
    bit e_dbl    = 1'b0;
    bit e_long   = 1'b0;
    bit prev_b   = 1'b0;
    int last_rise_cyc = 0;

    // Observations of the DUT.
    int n_click, n_dbl, n_long, n_rise;
    int fall_cyc, rise_cyc, click_cyc, dbl_cyc, long_cyc;
    bit obs_prev = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
        end
    endtask

    // Advance the model by the upcoming rising edge using the inputs about to be sampled.
    task automatic model_step();
        bit s2p;
        bit r;
        bit f;
        cyc++;
        e_click = 1'b0;
        e_dbl   = 1'b0;
        e_long  = 1'b0;
        if (sw) begin
            dl0 = 1'b0; dl1 = 1'b0; run = 0; m_pressed = 1'b0;
            m_presses = 0; m_long = 1'b0;
        end else begin
            s2p = dl1;
            dl1 = dl0;
            dl0 = btnC;
            r = 1'b0;
            f = 1'b0;
            if (s2p != m_pressed) begin
                run++;
                if (run == DEB) begin
                    m_pressed = s2p;
                    run = 0;
                    r = s2p;
                    f = !s2p;
                end
            end else begin
                run = 0;
            end
            if (r) begin
                m_presses++;
                t_mark = cyc;
            end else if (f) begin
                if (m_long) begin
                    m_presses = 0; m_long = 1'b0;
                end else if (m_presses == 2) begin
                    e_dbl = 1'b1; m_presses = 0;
                end else begin
                    t_mark = cyc;
                end
            end else if (m_pressed && m_presses > 0 && !m_long && cyc - t_mark == LONG) begin
                e_long = 1'b1;
                m_long = 1'b1;
            end else if (!m_pressed && m_presses == 1 && cyc - t_mark == DBL) begin
                e_click = 1'b1;
                m_presses = 0;
            end
        end
        if (btnC && !prev_b) last_rise_cyc = cyc;
        prev_b = btnC;
    endtask

    task automatic tick();
        model_step();
        @(negedge clk);
        check("pressed", pressed, m_pressed);
        check("click", click, e_click);
        check("dbl_click", dbl_click, e_dbl);
        check("long_press", long_press, e_long);
        if (click)      begin n_click++; click_cyc = cyc; end
        if (dbl_click)  begin n_dbl++;   dbl_cyc   = cyc; end
        if (long_press) begin n_long++;  long_cyc  = cyc; end
        if (pressed && !obs_prev) begin n_rise++; rise_cyc = cyc; end
        if (!pressed && obs_prev) fall_cyc = cyc;
        obs_prev = pressed;
    endtask

    task automatic hold(input bit lvl, input int n);
        btnC = lvl;
        repeat (n) tick();
    endtask

    task automatic clr();
        n_click = 0; n_dbl = 0; n_long = 0; n_rise = 0;
    endtask

    initial begin
        clr();
        // Reset with a toggling button.
        sw = 1'b1;
        for (int i = 0; i < 3; i++) begin
            btnC = i[0];
            tick();
        end
        sw = 1'b0;
        btnC = 1'b0;
        tick();
        check("rst_outputs", {28'd0, pressed, click, dbl_click, long_press}, 32'd0);
        clr();
        hold(1'b0, 50);
        check("idle_events", n_click + n_dbl + n_long + n_rise, 0);

        // Bounce shorter than the debounce window is rejected.
        clr();
        for (int i = 0; i < 15; i++) hold(i[0] ? 1'b0 : 1'b1, $urandom_range(1, 2));
        hold(1'b0, 20);
        check("bounce_no_press", n_rise, 0);
        check("bounce_no_event", n_click + n_dbl + n_long, 0);
        clr();
        for (int i = 0; i < 15; i++) hold(i[0] ? 1'b1 : 1'b0, $urandom_range(1, 3));
        hold(1'b1, 20);
        check("bounce_press_count", n_rise, 1);
        check("bounce_press_latency", rise_cyc - last_rise_cyc, DEB + 1);
        hold(1'b0, 40);

        // Single click.
        clr();
        hold(1'b1, 12);
        hold(1'b0, 40);
        check("single_click_cnt", n_click, 1);
        check("single_other_cnt", n_dbl + n_long, 0);
        check("single_click_delay", click_cyc - fall_cyc, DBL);

        // Double click.
        clr();
        hold(1'b1, 10); hold(1'b0, 8); hold(1'b1, 10); hold(1'b0, 40);
        check("double_cnt", n_dbl, 1);
        check("double_no_click", n_click + n_long, 0);
        check("double_timing", dbl_cyc - fall_cyc, 0);

        // Long press, then long press on the second press.
        clr();
        hold(1'b1, 60);
        check("long_delay", long_cyc - rise_cyc, LONG);
        hold(1'b0, 40);
        check("long_cnt", n_long, 1);
        check("long_no_click", n_click + n_dbl, 0);
        clr();
        hold(1'b1, 10); hold(1'b0, 8); hold(1'b1, 60); hold(1'b0, 40);
        check("long2_cnt", n_long, 1);
        check("long2_no_click", n_click + n_dbl, 0);

        // Second press lands exactly on the gap terminal edge.
        clr();
        hold(1'b1, 10); hold(1'b0, 16); hold(1'b1, 10);
        check("gap_tc_alignment", rise_cyc - fall_cyc, DBL);
        hold(1'b0, 40);
        check("gap_tc_no_click", n_click, 0);
        check("gap_tc_dbl", n_dbl, 1);

        // Reset in the gap drops the pending click.
        clr();
        hold(1'b1, 10); hold(1'b0, 8);
        sw = 1'b1;
        hold(1'b0, 2);
        sw = 1'b0;
        hold(1'b0, 40);
        check("rst_gap_no_click", n_click + n_dbl + n_long, 0);
        hold(1'b1, 12); hold(1'b0, 40);
        check("rst_gap_recover", n_click, 1);

        // Random activity, occasional resets with the button in either state.
        for (int g = 0; g < 60; g++) begin
            sw = ($urandom_range(0, 19) == 0);
            hold(g[0] ? 1'b0 : 1'b1, $urandom_range(1, 3));
            sw = 1'b0;
            hold(g[0] ? 1'b0 : 1'b1, $urandom_range(1, 70));
        end
        hold(1'b0, 100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
